// File: rtl/cp0_exc.sv
// CP0 exception/interrupt resolution for the M stage plus the Status/Cause/EPC/BadVAddr registers.
// Define CP0_TIMER_EN to add the Count/Compare timer driving Cause.IP[7].
module cp0_exc (
    input  logic        clk,
    input  logic        resetn,
    input  logic        laddrerrM,
    input  logic        saddrerrM,
    input  logic        adelifM,
    input  logic        syscallM,
    input  logic        breakM,
    input  logic        riM,
    input  logic        ovM,
    input  logic        eretM,
    input  logic        instvalidM,
    input  logic [31:0] pcM,
    input  logic [31:0] badaddrM,
    input  logic        bdM,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] excepttype_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);

    localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
    localparam logic [4:0]  ADDR_COUNT    = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
    localparam logic [4:0]  ADDR_STATUS   = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
    localparam logic [4:0]  ADDR_EPC      = 5'd14;
    localparam logic [31:0] EXC_VECTOR    = 32'hBFC0_0380;
    localparam logic [31:0] CODE_INT      = 32'h1;
    localparam logic [31:0] CODE_ERET     = 32'he;

    logic [31:0] r_status, r_cause, r_epc, r_badvaddr;
    logic [31:0] w_excepttype, w_count, w_compare;
    logic        w_int_pending, w_fetch_adel, w_exc_taken, w_eret_taken, w_we, w_timer_int;

    assign w_int_pending = instvalidM & r_status[0] & ~r_status[1]
                         & (|(r_cause[15:8] & r_status[15:8]));

    always_comb begin
        w_excepttype = 32'h0;
        w_fetch_adel = 1'b0;
        if (instvalidM) begin
            if (w_int_pending)  w_excepttype = CODE_INT;
            else if (adelifM) begin
                w_excepttype = 32'h4;
                w_fetch_adel = 1'b1;
            end
            else if (riM)       w_excepttype = 32'ha;
            else if (syscallM)  w_excepttype = 32'h8;
            else if (breakM)    w_excepttype = 32'h9;
            else if (ovM)       w_excepttype = 32'hc;
            else if (laddrerrM) w_excepttype = 32'h4;
            else if (saddrerrM) w_excepttype = 32'h5;
            else if (eretM)     w_excepttype = CODE_ERET;
        end
    end

    assign excepttype_o = w_excepttype;
    assign flush_o      = |w_excepttype;
    assign newpc_o      = (w_excepttype == CODE_ERET) ? r_epc : EXC_VECTOR;
    assign w_eret_taken = (w_excepttype == CODE_ERET);
    assign w_exc_taken  = flush_o & ~w_eret_taken;
    assign w_we         = we_i & ~flush_o;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_status   <= 32'h0040_0000;
            r_cause    <= 32'h0;
            r_epc      <= 32'h0;
            r_badvaddr <= 32'h0;
        end else begin
            r_cause[15:10] <= {int_i[5] | w_timer_int, int_i[4:0]};
            if (w_exc_taken) begin
                r_epc       <= bdM ? (pcM - 32'd4) : pcM;
                r_cause[31] <= bdM;
                r_cause[6:2] <= (w_excepttype == CODE_INT) ? 5'd0 : w_excepttype[4:0];
                r_status[1] <= 1'b1;
                if (w_fetch_adel)
                    r_badvaddr <= pcM;
                else if (w_excepttype == 32'h4 || w_excepttype == 32'h5)
                    r_badvaddr <= badaddrM;
            end else if (w_eret_taken) begin
                r_status[1] <= 1'b0;
            end else if (w_we) begin
                case (waddr_i)
                    ADDR_STATUS: begin
                        r_status[15:8] <= wdata_i[15:8];
                        r_status[1:0]  <= wdata_i[1:0];
                    end
                    ADDR_CAUSE: r_cause[9:8] <= wdata_i[9:8];
                    ADDR_EPC:   r_epc <= wdata_i;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] r_count, r_compare;
    logic        r_timer_int, r_count_tog;

    // Count advances on every second cycle; the toggle restarts on an mtc0 reload.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count     <= 32'h0;
            r_compare   <= 32'h0;
            r_timer_int <= 1'b0;
            r_count_tog <= 1'b0;
        end else begin
            if (w_we && waddr_i == ADDR_COUNT) begin
                r_count     <= wdata_i;
                r_count_tog <= 1'b0;
            end else begin
                r_count_tog <= ~r_count_tog;
                if (r_count_tog) r_count <= r_count + 32'd1;
            end
            if (w_we && waddr_i == ADDR_COMPARE) begin
                r_compare   <= wdata_i;
                r_timer_int <= 1'b0;
            end else if (r_count == r_compare && r_compare != 32'h0) begin
                r_timer_int <= 1'b1;
            end
        end
    end

    assign w_count     = r_count;
    assign w_compare   = r_compare;
    assign w_timer_int = r_timer_int;
`else
    assign w_count     = 32'h0;
    assign w_compare   = 32'h0;
    assign w_timer_int = 1'b0;
`endif

    always_comb begin
        case (raddr_i)
            ADDR_BADVADDR: rdata_o = r_badvaddr;
            ADDR_COUNT:    rdata_o = w_count;
            ADDR_COMPARE:  rdata_o = w_compare;
            ADDR_STATUS:   rdata_o = r_status;
            ADDR_CAUSE:    rdata_o = r_cause;
            ADDR_EPC:      rdata_o = r_epc;
            default:       rdata_o = 32'h0;
        endcase
    end

    assign status_o = r_status;
    assign cause_o  = r_cause;
    assign epc_o    = r_epc;

endmodule

// File: tb/tb_cp0_exc.sv
// Testbench for cp0_exc: directed scenarios plus randomized traffic against a field-level model.
module tb_cp0_exc;

    logic        clk, resetn;
    logic        laddrerrM, saddrerrM, adelifM, syscallM, breakM, riM, ovM, eretM, instvalidM, bdM;
    logic [31:0] pcM, badaddrM, wdata_i, rdata_o, excepttype_o, newpc_o, status_o, cause_o, epc_o;
    logic [5:0]  int_i;
    logic        we_i, flush_o;
    logic [4:0]  waddr_i, raddr_i;

    int n_checks = 0;
    int n_errors = 0;

    // model state, kept as individual architectural fields
    bit        m_ie, m_exl, m_bd;
    bit [7:0]  m_im;
    bit [5:0]  m_iphw;
    bit [1:0]  m_ipsw;
    bit [4:0]  m_code;
    bit [31:0] m_epc, m_badv;
    bit [31:0] m_count, m_cmp;
    bit        m_tog, m_tint;

    cp0_exc dut (
        .clk(clk), .resetn(resetn),
        .laddrerrM(laddrerrM), .saddrerrM(saddrerrM), .adelifM(adelifM),
        .syscallM(syscallM), .breakM(breakM), .riM(riM), .ovM(ovM), .eretM(eretM),
        .instvalidM(instvalidM), .pcM(pcM), .badaddrM(badaddrM), .bdM(bdM),
        .int_i(int_i), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .excepttype_o(excepttype_o), .flush_o(flush_o), .newpc_o(newpc_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_bd = 0; m_im = 0; m_iphw = 0; m_ipsw = 0; m_code = 0;
        m_epc = 0; m_badv = 0; m_count = 0; m_cmp = 0; m_tog = 0; m_tint = 0;
    endtask

    function automatic bit [31:0] m_status();
        return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic bit [31:0] m_cause();
        return (32'(m_bd) << 31) | (32'(m_iphw) << 10) | (32'(m_ipsw) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic bit [31:0] model_exc();
        bit          flg [9];
        int unsigned codes [9];
        bit          intp;
        intp  = instvalidM && m_ie && !m_exl && (({m_iphw, m_ipsw} & m_im) != 8'h0);
        flg   = '{intp, adelifM, riM, syscallM, breakM, ovM, laddrerrM, saddrerrM, eretM};
        codes = '{1, 4, 10, 8, 9, 12, 4, 5, 14};
        if (!instvalidM) return 32'h0;
        for (int i = 0; i < 9; i++)
            if (flg[i]) return codes[i];
        return 32'h0;
    endfunction

    function automatic bit [31:0] model_read(input bit [4:0] a);
        case (a)
            5'd8:  return m_badv;
            5'd12: return m_status();
            5'd13: return m_cause();
            5'd14: return m_epc;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_cmp;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive_idle();
        laddrerrM = 0; saddrerrM = 0; adelifM = 0; syscallM = 0; breakM = 0; riM = 0;
        ovM = 0; eretM = 0; instvalidM = 0; bdM = 0; pcM = 0; badaddrM = 0;
        int_i = 0; we_i = 0; waddr_i = 0; raddr_i = 0; wdata_i = 0;
    endtask

    // Check the cycle's outputs against the model at the falling edge, advance the model,
    // then let the rising edge happen; returns at posedge+1 ready for new inputs.
    task automatic cycle();
        bit [31:0] e;
        bit [5:0]  n_iphw;
        bit        wr, hit;
        @(negedge clk);
        e = model_exc();
        chk("exc",    excepttype_o, e);
        chk("flush",  {31'b0, flush_o}, {31'b0, e != 0});
        chk("newpc",  newpc_o, (e == 14) ? m_epc : 32'hBFC0_0380);
        chk("rdata",  rdata_o, model_read(raddr_i));
        chk("status", status_o, m_status());
        chk("cause",  cause_o, m_cause());
        chk("epc",    epc_o, m_epc);
        n_iphw = int_i;
        n_iphw[5] = int_i[5] | m_tint;
        wr  = we_i && (e == 0);
        hit = (m_count == m_cmp) && (m_cmp != 0);
        if (e != 0 && e != 14) begin
            m_epc  = bdM ? pcM - 32'd4 : pcM;
            m_bd   = bdM;
            m_code = (e == 1) ? 5'd0 : e[4:0];
            m_exl  = 1;
            if (e == 4 && adelifM)     m_badv = pcM;
            else if (e == 4 || e == 5) m_badv = badaddrM;
        end else if (e == 14) begin
            m_exl = 0;
        end else if (wr) begin
            case (waddr_i)
                5'd12: begin m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0]; end
                5'd13: m_ipsw = wdata_i[9:8];
                5'd14: m_epc = wdata_i;
                default: ;
            endcase
        end
`ifdef CP0_TIMER_EN
        if (wr && waddr_i == 5'd11) begin m_cmp = wdata_i; m_tint = 0; end
        else if (hit) m_tint = 1;
        if (wr && waddr_i == 5'd9) begin m_count = wdata_i; m_tog = 0; end
        else begin
            if (m_tog) m_count = m_count + 1;
            m_tog = !m_tog;
        end
`endif
        m_iphw = n_iphw;
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input bit [4:0] a, input bit [31:0] d);
        drive_idle();
        we_i = 1; waddr_i = a; wdata_i = d;
        cycle();
        drive_idle();
    endtask

    initial begin
        bit got_int;
        drive_idle();
        resetn = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        raddr_i = 5'd12;
        #1;
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause",  cause_o, 32'h0);
        chk("rst_epc",    epc_o, 32'h0);
        chk("rst_rdata",  rdata_o, 32'h0040_0000);
        resetn = 1;
        drive_idle();
        cycle();

        // data load address error
        instvalidM = 1; laddrerrM = 1; pcM = 32'hBFC0_0100; badaddrM = 32'h8000_0002;
        #2;
        chk("lw_exc",   excepttype_o, 32'h4);
        chk("lw_flush", {31'b0, flush_o}, 32'h1);
        chk("lw_newpc", newpc_o, 32'hBFC0_0380);
        cycle();
        drive_idle();
        raddr_i = 5'd8;
        #1;
        chk("lw_badv", rdata_o, 32'h8000_0002);
        chk("lw_epc",  epc_o, 32'hBFC0_0100);
        chk("lw_code", {27'b0, cause_o[6:2]}, 32'h4);
        chk("lw_exl",  {31'b0, status_o[1]}, 32'h1);
        cycle();

        // store error in a delay slot
        instvalidM = 1; saddrerrM = 1; bdM = 1; pcM = 32'hBFC0_0204; badaddrM = 32'h0000_1001;
        #2;
        chk("sh_exc", excepttype_o, 32'h5);
        cycle();
        drive_idle();
        chk("sh_epc", epc_o, 32'hBFC0_0200);
        chk("sh_bd",  {31'b0, cause_o[31]}, 32'h1);

        // simultaneous faults plus an mtc0 that must be dropped
        instvalidM = 1; riM = 1; ovM = 1; laddrerrM = 1; pcM = 32'hBFC0_0300;
        we_i = 1; waddr_i = 5'd14; wdata_i = 32'h1234_5678;
        #2;
        chk("multi_exc", excepttype_o, 32'ha);
        cycle();
        drive_idle();
        chk("multi_epc", epc_o, 32'hBFC0_0300);

        mtc0(5'd14, 32'hBFC0_0500);
        chk("mtc0_epc", epc_o, 32'hBFC0_0500);

        // eret
        instvalidM = 1; eretM = 1;
        #2;
        chk("eret_newpc", newpc_o, 32'hBFC0_0500);
        chk("eret_flush", {31'b0, flush_o}, 32'h1);
        cycle();
        drive_idle();
        chk("eret_exl", {31'b0, status_o[1]}, 32'h0);
        chk("eret_epc", epc_o, 32'hBFC0_0500);

        // hardware interrupt 0 through IM2
        drive_idle();
        we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_0401; int_i = 6'h01;
        cycle();
        drive_idle();
        int_i = 6'h01;
        chk("int_status", status_o, 32'h0040_0401);
        cycle();
        instvalidM = 1; pcM = 32'hBFC0_0600;
        #2;
        chk("int_exc", excepttype_o, 32'h1);
        cycle();
        chk("int_code", {27'b0, cause_o[6:2]}, 32'h0);
        chk("int_exl",  {31'b0, status_o[1]}, 32'h1);
        #2;
        chk("int_masked", excepttype_o, 32'h0);
        cycle();
        drive_idle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive_idle();
            instvalidM = ($urandom_range(0, 9) < 7);
            adelifM   = ($urandom_range(0, 15) == 0);
            riM       = ($urandom_range(0, 15) == 0);
            syscallM  = ($urandom_range(0, 15) == 0);
            breakM    = ($urandom_range(0, 15) == 0);
            ovM       = ($urandom_range(0, 15) == 0);
            laddrerrM = ($urandom_range(0, 15) == 0);
            saddrerrM = ($urandom_range(0, 15) == 0);
            eretM     = ($urandom_range(0, 7) == 0);
            bdM       = $urandom_range(0, 1);
            pcM       = $urandom & 32'hFFFF_FFFC;
            badaddrM  = $urandom;
            int_i     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            we_i      = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 6))
                0: waddr_i = 5'd8;
                1: waddr_i = 5'd9;
                2: waddr_i = 5'd11;
                3: waddr_i = 5'd12;
                4: waddr_i = 5'd13;
                5: waddr_i = 5'd14;
                default: waddr_i = 5'($urandom_range(0, 31));
            endcase
            wdata_i = $urandom;
            raddr_i = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(8, 14)) : 5'($urandom_range(0, 31));
            cycle();
        end
        drive_idle();

`ifdef CP0_TIMER_EN
        mtc0(5'd12, 32'h0);
        mtc0(5'd11, 32'h4);
        mtc0(5'd9,  32'h0);
        mtc0(5'd12, 32'h0000_8001);
        got_int = 0;
        for (int n = 0; n < 40 && !got_int; n++) begin
            instvalidM = 1; pcM = 32'hBFC0_0700;
            #2;
            if (excepttype_o == 32'h1) got_int = 1;
            cycle();
        end
        drive_idle();
        chk("tmr_taken", {31'b0, got_int}, 32'h1);
        mtc0(5'd11, 32'h100);
        cycle();
        chk("tmr_ip7_clr", {31'b0, cause_o[15]}, 32'h0);
`else
        got_int = 0;
        raddr_i = 5'd9;
        #1;
        chk("no_count", rdata_o, 32'h0);
`endif

        // reset asserted with an exception in flight
        drive_idle();
        instvalidM = 1; laddrerrM = 1; pcM = 32'hBFC0_0800; badaddrM = 32'h0000_0003;
        #2;
        resetn = 0;
        #1;
        chk("arst_status", status_o, 32'h0040_0000);
        chk("arst_epc",    epc_o, 32'h0);
        chk("arst_cause",  cause_o, 32'h0);
        model_reset();
        drive_idle();
        @(posedge clk);
        #1;
        resetn = 1;
        raddr_i = 5'd8;
        #1;
        chk("arst_badv", rdata_o, 32'h0);
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
